// File: rtl/phase_vote_filter_pkg.sv
// Shared types and width helpers for the phase_vote_filter CDR loop filter.
package phase_vote_pkg;

  typedef enum logic [1:0] {
    VOTE_NONE,
    VOTE_UP,
    VOTE_DN
  } vote_e;

  function automatic int diff_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  // Counter must be able to hold LOCK_CNT itself, hence +1.
  function automatic int lock_cnt_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/phase_vote_filter_lock_counter.sv
// Saturating step-free sample counter; locked while it sits at LOCK_CNT.
module phase_lock_counter
  import phase_vote_pkg::*;
#(
  parameter int LOCK_CNT = 16
) (
  input  logic clk_cont,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic locked
);

  localparam int CW = lock_cnt_w(LOCK_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_cont or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign locked = (cnt == CNT_MAX);

endmodule

// File: rtl/phase_vote_filter.sv
// Early/late comparator plus bang-bang loop-filter accumulator with up/dn step pulses.
// Optional lock detector compiled in with `define PHASE_VOTE_LOCK_EN.
module phase_vote_filter
  import phase_vote_pkg::*;
#(
  parameter int CNT_W    = 2,
  parameter int ACC_W    = 6,
  parameter int THRESH   = 8,
  parameter int LOCK_CNT = 16
) (
  input  logic                    clk_cont,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        ea,
  input  logic [CNT_W-1:0]        la,
  output logic                    comp,
  output logic                    equal,
  output logic                    up,
  output logic                    dn,
  output logic signed [ACC_W-1:0] acc,
  output logic                    locked
);

  localparam int DW = diff_w(CNT_W);

  if ((THRESH < 1) || (THRESH + (2 ** CNT_W) - 1 > (2 ** (ACC_W - 1)) - 1) || (LOCK_CNT < 1))
  begin : g_bad_params
    $error("phase_vote_filter: THRESH/CNT_W/ACC_W/LOCK_CNT combination can overflow acc");
  end

  localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

  logic signed [DW-1:0]    diff;
  logic signed [ACC_W-1:0] acc_next;
  vote_e                   vote;

  assign diff     = {1'b0, ea} - {1'b0, la};
  assign acc_next = acc + {{(ACC_W - DW){diff[DW-1]}}, diff};

  always_comb begin
    vote = VOTE_NONE;
    if (en) begin
      if (acc_next >= THR_P) begin
        vote = VOTE_UP;
      end else if (acc_next <= THR_N) begin
        vote = VOTE_DN;
      end
    end
  end

  always_ff @(posedge clk_cont or posedge rst) begin
    if (rst) begin
      comp  <= 1'b0;
      equal <= 1'b1;
      up    <= 1'b0;
      dn    <= 1'b0;
      acc   <= '0;
    end else begin
      up <= (vote == VOTE_UP);
      dn <= (vote == VOTE_DN);
      if (en) begin
        if (ea > la) begin
          comp  <= 1'b1;
          equal <= 1'b0;
        end else if (ea < la) begin
          comp  <= 1'b0;
          equal <= 1'b0;
        end else begin
          equal <= 1'b1;
        end
        acc <= (vote == VOTE_NONE) ? acc_next : '0;
      end
    end
  end

`ifdef PHASE_VOTE_LOCK_EN
  phase_lock_counter #(
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .clk_cont(clk_cont),
    .rst     (rst),
    .clr     (en && (vote != VOTE_NONE)),
    .inc     (en && (vote == VOTE_NONE)),
    .locked  (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_phase_vote_filter.sv
// Directed bench for phase_vote_filter at default parameters (lock expectations follow PHASE_VOTE_LOCK_EN).
module tb_phase_vote_filter;

`ifdef PHASE_VOTE_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic              clk_cont = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [1:0]        ea = '0;
  logic [1:0]        la = '0;
  logic              comp, equal, up, dn, locked;
  logic signed [5:0] acc;

  int checks = 0;
  int errors = 0;

  phase_vote_filter #(
    .CNT_W   (2),
    .ACC_W   (6),
    .THRESH  (8),
    .LOCK_CNT(16)
  ) dut (
    .clk_cont(clk_cont),
    .rst     (rst),
    .en      (en),
    .ea      (ea),
    .la      (la),
    .comp    (comp),
    .equal   (equal),
    .up      (up),
    .dn      (dn),
    .acc     (acc),
    .locked  (locked)
  );

  always #5 clk_cont = ~clk_cont;

  typedef struct {
    logic       en;
    logic [1:0] ea;
    logic [1:0] la;
    logic       comp;
    logic       equal;
    logic       up;
    logic       dn;
    int         acc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, int a, int l, logic c, logic q, logic u, logic d, int ac);
    vec_t v;
    v.en = e; v.ea = 2'(a); v.la = 2'(l);
    v.comp = c; v.equal = q; v.up = u; v.dn = d; v.acc = ac;
    return v;
  endfunction

  task automatic check(input string nm, input logic ec, input logic eq, input logic eu,
                       input logic ed, input int eacc, input logic el);
    checks++;
    if (comp !== ec || equal !== eq || up !== eu || dn !== ed ||
        int'(acc) != eacc || locked !== el) begin
      errors++;
      $display("FAIL %s: got comp=%b equal=%b up=%b dn=%b acc=%0d locked=%b, expected comp=%b equal=%b up=%b dn=%b acc=%0d locked=%b",
               nm, comp, equal, up, dn, acc, locked, ec, eq, eu, ed, eacc, el);
    end
  endtask

  task automatic sample(input logic e, input int a, input int l);
    @(negedge clk_cont);
    en = e; ea = 2'(a); la = 2'(l);
    @(posedge clk_cont);
    #1;
  endtask

  initial begin
    // advance
    tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 6));
    tbl.push_back(mk(1, 3, 0, 1, 0, 1, 0, 0));
    // preload 6 then hold with en=0
    tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 6));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 6));
    tbl.push_back(mk(1, 3, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0));
    // retard
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, -2));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, -4));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, -6));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 0));
    // equal holds comp, then mixed
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, -2));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, -5));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1, 0));

    // reset
    repeat (2) @(posedge clk_cont);
    #1 check("reset_held", 0, 1, 0, 0, 0, 0);
    @(negedge clk_cont);
    rst = 1'b0;
    @(posedge clk_cont);
    #1 check("reset_release", 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      sample(tbl[i].en, int'(tbl[i].ea), int'(tbl[i].la));
      check($sformatf("vec%0d", i), tbl[i].comp, tbl[i].equal, tbl[i].up, tbl[i].dn, tbl[i].acc, 1'b0);
    end

    // async reset mid-accumulation
    for (int i = 1; i <= 3; i++) sample(1, 0, 2);
    check("async_pre", 0, 0, 0, 0, -6, 0);
    @(negedge clk_cont);
    en = 1'b0;
    #1 rst = 1'b1;
    #1 check("async_rst", 0, 1, 0, 0, 0, 0);
    #1 rst = 1'b0;
    sample(1, 2, 0);
    check("async_after", 1, 0, 0, 0, 2, 0);

    // lock: fresh reset, 16 equal samples
    @(negedge clk_cont);
    en = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      sample(1, 1, 1);
      check($sformatf("lock_run%0d", i), 0, 1, 0, 0, 0, LK && (i == 16));
    end
    sample(1, 3, 0);
    check("lock_pre3", 1, 0, 0, 0, 3, LK);
    sample(1, 3, 0);
    check("lock_pre6", 1, 0, 0, 0, 6, LK);
    sample(1, 3, 0);
    check("lock_step", 1, 0, 1, 0, 0, 0);
    sample(0, 0, 0);
    check("lock_after", 1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
